// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 128-bit state in, COLS_PER_CYCLE columns
// transformed per clock, result returned over a valid/ready handshake.
module inv_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] i_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] o_block,
   output logic         busy
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
       COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

   state_t       state, state_nx;
   logic [127:0] work, work_nx;
   logic [127:0] out_q;
   logic [2:0]   col_cnt;
   logic         take;
   logic         last;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m9(input logic [7:0] a);
      return xt(xt(xt(a))) ^ a;
   endfunction

   function automatic logic [7:0] mb(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(a) ^ a;
   endfunction

   function automatic logic [7:0] md(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
   endfunction

   function automatic logic [7:0] me(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
   endfunction

   // c0 is the top byte, b0 lands in the bottom byte
   function automatic logic [31:0] imc(input logic [31:0] col);
      logic [7:0] c0, c1, c2, c3;
      logic [7:0] b0, b1, b2, b3;
      c0 = col[31:24];
      c1 = col[23:16];
      c2 = col[15:8];
      c3 = col[7:0];
      b0 = me(c0) ^ mb(c1) ^ md(c2) ^ m9(c3);
      b1 = m9(c0) ^ me(c1) ^ mb(c2) ^ md(c3);
      b2 = md(c0) ^ m9(c1) ^ me(c2) ^ mb(c3);
      b3 = mb(c0) ^ md(c1) ^ m9(c2) ^ me(c3);
      return {b3, b2, b1, b0};
   endfunction

   assign last    = (col_cnt + STEP) == 3'd4;
   assign o_block = out_q;

   always_comb begin
      work_nx = work;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         if (int'(col_cnt) + j < 4) begin
            work_nx[(int'(col_cnt) + j) * 32 +: 32] =
               imc(work[(int'(col_cnt) + j) * 32 +: 32]);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      take      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               take     = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  take     = 1'b1;
                  state_nx = BUSY;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         col_cnt <= 3'd0;
         work    <= '0;
         out_q   <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            work    <= i_block;
            col_cnt <= 3'd0;
         end else if (state == BUSY) begin
            work    <= work_nx;
            col_cnt <= col_cnt + STEP;
         end
         if (state == BUSY && last) out_q <= work_nx;
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: three instances (1, 2 and 4 columns per
// cycle) checked against a matrix-level GF(2^8) reference model.
module tb_inv_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] i_block   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] o_block   [3];
   logic         busy      [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
         .clk(clk),
         .rst_n(rst_n),
         .in_valid(in_valid[g]),
         .in_ready(in_ready[g]),
         .i_block(i_block[g]),
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .o_block(o_block[g]),
         .busy(busy[g])
      );
   end

   localparam logic [7:0] IM [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
   localparam logic [7:0] EM [4] = '{8'h02, 8'h03, 8'h01, 8'h01};

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // reads c_k from the top byte down, writes b_r from the bottom byte up
   function automatic logic [127:0] ref_inv(input logic [127:0] blk);
      logic [127:0] res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(IM[(k - r + 4) % 4], blk[32*c + 31 - 8*k -: 8]);
            res[32*c + 8*r +: 8] = acc;
         end
      end
      return res;
   endfunction

   // encrypt-side packing: the exact mirror of ref_inv's byte order
   function automatic logic [127:0] ref_mix(input logic [127:0] blk);
      logic [127:0] res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(EM[(k - r + 4) % 4], blk[32*c + 8*k +: 8]);
            res[32*c + 31 - 8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // returns just after the edge on which the input handshake happened
   task automatic push(input int k, input logic [127:0] b, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      in_valid[k] = 1'b1;
      i_block[k]  = b;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (in_ready[k] === 1'b1) begin
            @(posedge clk);
            #1;
            in_valid[k] = 1'b0;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      in_valid[k] = 1'b0;
   endtask

   // lat counts edges after the input handshake until out_valid shows
   task automatic pull(input int k, output logic [127:0] r,
                       output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      r   = '0;
      for (int t = 0; t < 40; t++) begin
         if (out_valid[k] === 1'b1) begin
            r  = o_block[k];
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      if (ok && out_ready[k]) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #12;
      for (int k = 0; k < 3; k++) begin
         checks += 4;
         if (in_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready[%0d] got %b exp 0", k, in_ready[k]);
         end
         if (out_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid[%0d] got %b exp 0", k, out_valid[k]);
         end
         if (busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]);
         end
         if (o_block[k] !== 128'h0) begin
            errors++;
            $display("FAIL reset_o_block[%0d] got %h exp 0", k, o_block[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready[%0d] got %b exp 1", k, in_ready[k]);
         end
      end
   endtask

   task automatic test_vectors();
      logic [127:0] r;
      int lat;
      bit ok1, ok2;
      logic [127:0] vin  [2];
      logic [127:0] vexp [2];
      vin[0]  = {4{32'h8e4da1bc}};
      vexp[0] = {4{32'h455313db}};
      vin[1]  = {32'h9fdc589d, 32'h8e4da1bc, 32'h01010101, 32'hc6c6c6c6};
      vexp[1] = {32'h5c220af2, 32'h455313db, 32'h01010101, 32'hc6c6c6c6};
      for (int v = 0; v < 2; v++) begin
         push(0, vin[v], ok1);
         pull(0, r, lat, ok2);
         checks += 2;
         if (!(ok1 && ok2) || r !== vexp[v]) begin
            errors++;
            $display("FAIL vector%0d got %h exp %h", v, r, vexp[v]);
         end
         if (lat !== 4) begin
            errors++;
            $display("FAIL vector%0d_latency got %0d exp 4", v, lat);
         end
      end
   endtask

   task automatic test_round_trip();
      logic [127:0] x, r;
      int lat, bad;
      bit ok1, ok2;
      for (int k = 0; k < 3; k++) begin
         bad = 0;
         for (int n = 0; n < 1000; n++) begin
            x = rnd128();
            push(k, ref_mix(x), ok1);
            pull(k, r, lat, ok2);
            checks++;
            if (!(ok1 && ok2) || r !== x || lat !== (4 >> k)) begin
               errors++;
               if (bad++ < 4)
                  $display("FAIL round_trip cols=%0d got %h lat %0d exp %h lat %0d",
                           1 << k, r, lat, x, 4 >> k);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] a, b, ea, r;
      int lat;
      bit ok1, ok2;
      a  = rnd128();
      b  = rnd128();
      ea = ref_inv(a);
      out_ready[0] = 1'b0;
      push(0, a, ok1);
      pull(0, r, lat, ok2);
      checks++;
      if (!(ok1 && ok2) || r !== ea) begin
         errors++;
         $display("FAIL bp_first got %h exp %h", r, ea);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (out_valid[0] !== 1'b1 || o_block[0] !== ea || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall cyc %0d got v=%b r=%b %h exp v=1 r=0 %h",
                     i, out_valid[0], in_ready[0], o_block[0], ea);
         end
      end
      @(negedge clk);
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      i_block[0]   = b;
      #1;
      checks++;
      if (in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_in_ready got %b exp 1", in_ready[0]);
      end
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_b2b_accept got v=%b busy=%b exp v=0 busy=1",
                  out_valid[0], busy[0]);
      end
      pull(0, r, lat, ok2);
      checks++;
      if (!ok2 || r !== ref_inv(b) || lat !== 4) begin
         errors++;
         $display("FAIL bp_second got %h lat %0d exp %h lat 4", r, lat, ref_inv(b));
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [127:0] a, b, r;
      int lat;
      bit ok1, ok2;
      a = rnd128();
      b = rnd128();
      push(0, a, ok1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (!ok1 || out_valid[0] !== 1'b0 || o_block[0] !== 128'h0 ||
          in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs got v=%b r=%b busy=%b %h exp 0 0 0 0",
                  out_valid[0], in_ready[0], busy[0], o_block[0]);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL midrst_in_ready got %b exp 1", in_ready[0]);
      end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_spurious cyc %0d got %b exp 0", i, out_valid[0]);
         end
         @(negedge clk);
      end
      push(0, b, ok1);
      pull(0, r, lat, ok2);
      checks++;
      if (!(ok1 && ok2) || r !== ref_inv(b) || lat !== 4) begin
         errors++;
         $display("FAIL midrst_next got %h lat %0d exp %h lat 4", r, lat, ref_inv(b));
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] q [$];
      logic [127:0] cur, e, prev_ob;
      int sent = 0, got = 0, cyc = 0;
      bit prev_stall = 1'b0;
      bit fi, fo;
      cur = rnd128();
      prev_ob = '0;
      while (got < 100 && cyc < 3000) begin
         @(negedge clk);
         out_ready[1] = ($urandom_range(0, 3) != 0);
         in_valid[1]  = (sent < 100);
         i_block[1]   = cur;
         #2;
         if (prev_stall) begin
            checks++;
            if (out_valid[1] !== 1'b1 || o_block[1] !== prev_ob) begin
               errors++;
               $display("FAIL b2b_hold got v=%b %h exp v=1 %h",
                        out_valid[1], o_block[1], prev_ob);
            end
         end
         fi = in_valid[1] && in_ready[1];
         fo = out_valid[1] && out_ready[1];
         if (fo) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious got %h exp none", o_block[1]);
            end else begin
               e = q.pop_front();
               if (o_block[1] !== e) begin
                  errors++;
                  $display("FAIL b2b_data blk %0d got %h exp %h", got, o_block[1], e);
               end
            end
            got++;
         end
         if (fi) begin
            q.push_back(ref_inv(cur));
            sent++;
            cur = rnd128();
         end
         prev_stall = out_valid[1] && !out_ready[1];
         prev_ob    = o_block[1];
         cyc++;
      end
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      checks++;
      if (sent !== 100 || got !== 100 || q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count got in %0d out %0d left %0d exp 100 100 0",
                  sent, got, q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b1;
         i_block[k]   = '0;
      end
      test_reset();
      test_vectors();
      test_round_trip();
      test_backpressure();
      test_reset_mid_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
